// File: rtl/binary16_to_bcd.sv
// -----------------------------------------------------------------------------
// binary16_to_bcd
//
// Converts a 16-bit unsigned binary value into five packed BCD digits using the
// iterative shift-and-add-3 (double dabble) method, one input bit per clock,
// MSB first.
//
// Ports
//   clk     in   1   rising-edge clock for all state
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request conversion of `binary` (ignored while busy)
//   binary  in  16   unsigned operand, captured on the accepting edge
//   bcd     out 20   last completed result, {10000s,1000s,100s,10s,1s}
//   busy    out  1   high while a conversion is in flight (SHIFT and DONE)
//   done    out  1   one-cycle pulse when `bcd` has just been updated
//
// Timing: start accepted at edge E0, sixteen shifts on E1..E16, result
// published on E17 (done and bcd valid after E17). The earliest next start is
// accepted on E18, giving one result every 18 cycles when start is held high.
// -----------------------------------------------------------------------------
module binary16_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] binary,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] acc_q,   acc_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [19:0] bcd_q,   bcd_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [19:0] acc_adj_s;

  // Add 3 to a single BCD digit when it is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Apply the add-3 correction to all five digits of the accumulator.
  function automatic logic [19:0] adjust_digits(input logic [19:0] a);
    logic [19:0] r;
    r = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = add3(a[i*4 +: 4]);
    end
    return r;
  endfunction

  // Digit correction applied before every shift.
  always_comb begin
    acc_adj_s = adjust_digits(acc_q);
  end

  // Next-state and datapath logic; every register holds unless told otherwise.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = binary;
          acc_d   = 20'h00000;
          cnt_d   = 5'd16;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // The accumulator's MSB is always 0 after correction for 16-bit
        // operands (max 65535 fits in 20 BCD bits), so dropping it is safe.
        acc_d   = {acc_adj_s[18:0], shift_q[15]};
        shift_d = {shift_q[14:0], 1'b0};
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end

      DONE: begin
        // Only here is the output register touched, so intermediate
        // accumulator values never appear on bcd.
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 16'h0000;
      acc_q   <= 20'h00000;
      cnt_q   <= 5'd0;
      bcd_q   <= 20'h00000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_binary16_to_bcd.sv
// -----------------------------------------------------------------------------
// Self-checking bench for binary16_to_bcd. Expected results come from a decimal
// reference model built with integer division and modulo.
// -----------------------------------------------------------------------------
module tb_binary16_to_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] binary;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  binary16_to_bcd dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .binary (binary),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: peel off base-10 digits with plain arithmetic.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = 20'h00000;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [19:0] b);
    logic ok;
    ok = (b[19:16] <= 4'd6);
    for (int k = 0; k < 4; k++) begin
      if (b[k*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One conversion with a one-cycle start pulse; checks latency, result,
  // digit range and that done lasts exactly one cycle. `binary` is scrambled
  // right after capture to show the in-flight result is unaffected.
  task automatic run_conv(input logic [15:0] v, input string tag);
    int n;
    @(negedge clk);
    start  = 1'b1;
    binary = v;
    @(posedge clk);              // E0
    @(negedge clk);
    start  = 1'b0;
    binary = 16'($urandom);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, n, 32'd17);
    check({tag, " bcd"}, {12'd0, bcd}, {12'd0, ref_bcd(int'(v))});
    check({tag, " digits"}, {31'd0, digits_ok(bcd)}, 32'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    start  = 1'b0;
    binary = 16'h0000;
    rst_n  = 1'b0;

    #12;
    check("reset bcd",  {12'd0, bcd}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values, then boundaries.
    run_conv(16'd5555,  "c5555");
    run_conv(16'd1234,  "c1234");
    run_conv(16'd9876,  "c9876");
    run_conv(16'd2025,  "c2025");
    run_conv(16'd0,     "c0");
    run_conv(16'd65535, "c65535");
    run_conv(16'd9,     "c9");
    run_conv(16'd10,    "c10");
    run_conv(16'd99,    "c99");
    run_conv(16'd100,   "c100");
    run_conv(16'd59999, "c59999");
    run_conv(16'd60000, "c60000");

    // Start while busy is ignored.
    @(negedge clk);
    start  = 1'b1;
    binary = 16'd1234;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    binary = 16'd9999;
    @(negedge clk);
    start  = 1'b0;
    dones  = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        dones++;
        check("ignore bcd", {12'd0, bcd}, {12'd0, ref_bcd(1234)});
      end
      @(negedge clk);
    end
    check("ignore done count", dones, 32'd1);

    // Reset mid-conversion: start 9876, assert rst_n at cycle 8.
    @(negedge clk);
    start  = 1'b1;
    binary = 16'd9876;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst bcd",  {12'd0, bcd}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst no done", dones, 32'd0);
    check("midrst bcd hold", {12'd0, bcd}, 32'd0);
    run_conv(16'd42, "after_rst42");

    // Random operands.
    for (int i = 0; i < 1200; i++) begin
      run_conv(16'($urandom), "rand");
    end

    // Back-to-back with start held high: capture every 18 edges.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      binary = 16'(i);
      for (int c = 0; c < 18; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c == 0) binary = 16'($urandom);
        if (c == 17) begin
          check("b2b done", {31'd0, done}, 32'd1);
          check("b2b bcd", {12'd0, bcd}, {12'd0, ref_bcd(i)});
        end else begin
          check("b2b idle_done", {31'd0, done}, 32'd0);
        end
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/binary16_to_bcd.md
BINARY16_TO_BCD -- requirements
Module: binary16_to_bcd

Interface
REQ-001 Parameters: none; the input width is fixed at 16 bits and the output is fixed at 5 BCD digits.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request conversion of `binary`; sampled on rising clk.
REQ-006 binary  input  16  unsigned value to convert (0..65535).
REQ-007 bcd  output  20  packed BCD result:
- [19:16] ten-thousands digit
- [15:12] thousands
- [11:8] hundreds
- [7:4] tens
- [3:0] units
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when `bcd` has been updated with a new result.

Function
REQ-010 Algorithm: iterative shift-and-add-3 (double dabble), one input bit per clock, MSB first.
REQ-011 FSM states: IDLE, SHIFT, DONE.
REQ-012 IDLE transition: start=1 at a rising edge -> capture `binary` into an internal shift register, clear the digit accumulator, load the bit counter with 16, enter SHIFT.
REQ-013 SHIFT, each cycle:
- every accumulator digit >=5 gets +3;
- then the accumulator/shift register shifts left by one;
- the counter decrements.
REQ-014 SHIFT exit: after the 16th shift, the state moves to DONE.
REQ-015 DONE: `bcd` is loaded with the accumulator, `done` is high for exactly that one cycle, and the state returns to IDLE on the next edge.
REQ-016 Latency: start accepted at edge E0 -> `bcd` valid and `done`=1 after edge E17.
REQ-017 Throughput: a new start is accepted in the cycle after DONE.
REQ-018 `busy` is 1 in SHIFT and DONE, and 0 in IDLE.
REQ-019 start while busy=1 is ignored; the captured operand is unaffected.
REQ-020 `binary` changes after the capture edge do not affect the result in flight.
REQ-021 `bcd` holds the last completed result until the next DONE and never shows intermediate accumulator values.
REQ-022 Every digit of `bcd` is in 0..9; bcd[19:16] is in 0..6.
REQ-023 The result is exact for all 65536 inputs, e.g. 65535 -> 20'h65535.

Reset
REQ-024 Asserting rst_n=0 immediately, regardless of the clock, forces:
- state = IDLE;
- bcd = 20'h00000;
- busy = 0;
- done = 0;
- counter and shift registers = 0.
REQ-025 Reset asserted mid-conversion aborts it; no done pulse occurs and bcd reads 0.
REQ-026 After rst_n deasserts, the first rising edge with start=1 begins a normal conversion.

Verification
REQ-027 Convert 5555, 1234, 9876 and 2025 in turn, each with a one-cycle start pulse -> after each done, bcd = 20'h05555, 20'h01234, 20'h09876, 20'h02025 respectively, with done high for one cycle 17 edges after start.
REQ-028 Boundary operands:
- binary=0 -> bcd=20'h00000 with done pulse;
- binary=65535 -> bcd=20'h65535;
- binary=9 -> 20'h00009;
- binary=10 -> 20'h00010.
REQ-029 Start 1234, then pulse start with binary=9999 while busy -> result is 20'h01234 and exactly one done pulse occurs.
REQ-030 Start 9876, assert rst_n=0 at cycle 8 -> bcd, busy and done go to 0 immediately; after release, converting 42 yields 20'h00042.
REQ-031 Back-to-back conversions (start held high continuously, binary stepping through 0..999) -> each done reports the correct BCD of the operand captured at its start, every 18 cycles.
REQ-032 Exhaustive sweep of all 16-bit inputs, compared against a decimal reference model -> zero mismatches and no digit above 9.
